// File: rtl/moxie_wb_pkg.sv
// Shared types, widths and arbitration helpers for the Moxie Wishbone I/D arbiter.
package moxie_wb_pkg;

  localparam int WB_AW   = 32;
  localparam int WB_DW   = 32;
  localparam int GRANT_I = 0;
  localparam int GRANT_D = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  // Width of the watchdog counter; a disabled watchdog still needs a legal 1-bit vector.
  function automatic int wdCountWidth(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

  function automatic arb_state_t pickGrant(input logic iReq, input logic dReq,
                                           input logic lastWasD);
    if (iReq && dReq) return lastWasD ? GNT_I : GNT_D;
    if (iReq) return GNT_I;
    if (dReq) return GNT_D;
    return IDLE;
  endfunction

endpackage

// File: rtl/wb_bus_watchdog.sv
// Counts strobed cycles that see no ack/err and pulses timeout_o once the limit is hit.
module wb_bus_watchdog
  import moxie_wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic stb_i,
  input  logic ack_i,
  input  logic err_i,
  input  logic clear_i,
  output logic timeout_o
);

  localparam int CW = wdCountWidth(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count_q, count_d;
  logic          expired;

  assign expired   = (TIMEOUT_CYCLES != 0) && stb_i && (count_q == LIMIT);
  // A real ack in the expiry cycle completes the transfer, so it suppresses the error.
  assign timeout_o = expired && !ack_i;

  always_comb begin
    count_d = count_q + CW'(1);
    if ((TIMEOUT_CYCLES == 0) || clear_i || !stb_i || ack_i || err_i || expired)
      count_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/moxie_wb_arbiter.sv
// Round-robin Wishbone arbiter sharing one slave port between the Moxie I-fetch and data masters.
module moxie_wb_arbiter
  import moxie_wb_pkg::*;
#(
  parameter int AW             = WB_AW,
  parameter int DW             = WB_DW,
  parameter int TIMEOUT_CYCLES = 255,
  parameter bit RESET_LAST     = 1'b0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wbi_cyc_i,
  input  logic            wbi_stb_i,
  input  logic            wbi_we_i,
  input  logic [AW-1:0]   wbi_adr_i,
  input  logic [DW-1:0]   wbi_dat_i,
  input  logic [DW/8-1:0] wbi_sel_i,
  output logic [DW-1:0]   wbi_dat_o,
  output logic            wbi_ack_o,
  output logic            wbi_err_o,
  input  logic            wbd_cyc_i,
  input  logic            wbd_stb_i,
  input  logic            wbd_we_i,
  input  logic [AW-1:0]   wbd_adr_i,
  input  logic [DW-1:0]   wbd_dat_i,
  input  logic [DW/8-1:0] wbd_sel_i,
  output logic [DW-1:0]   wbd_dat_o,
  output logic            wbd_ack_o,
  output logic            wbd_err_o,
  output logic            wbs_cyc_o,
  output logic            wbs_stb_o,
  output logic            wbs_we_o,
  output logic [AW-1:0]   wbs_adr_o,
  output logic [DW-1:0]   wbs_dat_o,
  output logic [DW/8-1:0] wbs_sel_o,
  input  logic [DW-1:0]   wbs_dat_i,
  input  logic            wbs_ack_i,
  input  logic            wbs_err_i,
  output logic [1:0]      grant_o
);

  arb_state_t state_q, state_d;
  logic       lastGrant_q, lastGrant_d;
  logic       timeout, wdClear, slvAck, slvErr;

  // The owner keeps the bus while its cyc is high; on release the waiting master gets the same edge.
  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    case (state_q)
      IDLE: state_d = pickGrant(wbi_cyc_i, wbd_cyc_i, lastGrant_q);
      GNT_I:
        if (!wbi_cyc_i) begin
          lastGrant_d = 1'b0;
          state_d     = pickGrant(wbi_cyc_i, wbd_cyc_i, 1'b0);
        end
      GNT_D:
        if (!wbd_cyc_i) begin
          lastGrant_d = 1'b1;
          state_d     = pickGrant(wbi_cyc_i, wbd_cyc_i, 1'b1);
        end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      lastGrant_q <= RESET_LAST;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
    end
  end

  always_comb begin
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_we_o  = 1'b0;
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    case (state_q)
      GNT_I: begin
        wbs_cyc_o = wbi_cyc_i;
        wbs_stb_o = wbi_cyc_i & wbi_stb_i;
        wbs_we_o  = wbi_we_i;
        wbs_adr_o = wbi_adr_i;
        wbs_dat_o = wbi_dat_i;
        wbs_sel_o = wbi_sel_i;
      end
      GNT_D: begin
        wbs_cyc_o = wbd_cyc_i;
        wbs_stb_o = wbd_cyc_i & wbd_stb_i;
        wbs_we_o  = wbd_we_i;
        wbs_adr_o = wbd_adr_i;
        wbs_dat_o = wbd_dat_i;
        wbs_sel_o = wbd_sel_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    grant_o          = '0;
    grant_o[GRANT_I] = (state_q == GNT_I);
    grant_o[GRANT_D] = (state_q == GNT_D);
  end

  assign wdClear = (state_d != state_q);

  wb_bus_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .stb_i    (wbs_stb_o),
    .ack_i    (wbs_ack_i),
    .err_i    (wbs_err_i),
    .clear_i  (wdClear),
    .timeout_o(timeout)
  );

  // Slave responses only count while a strobe is actually on the bus.
  assign slvAck = wbs_ack_i & wbs_stb_o;
  assign slvErr = (wbs_err_i & wbs_stb_o) | timeout;

  assign wbi_ack_o = grant_o[GRANT_I] & slvAck;
  assign wbi_err_o = grant_o[GRANT_I] & slvErr;
  assign wbd_ack_o = grant_o[GRANT_D] & slvAck;
  assign wbd_err_o = grant_o[GRANT_D] & slvErr;

  assign wbi_dat_o = (state_q != IDLE) ? wbs_dat_i : '0;
  assign wbd_dat_o = (state_q != IDLE) ? wbs_dat_i : '0;

endmodule

// File: tb/tb_moxie_wb_arbiter.sv
// Directed and randomized check of moxie_wb_arbiter against a bus-owner level model.
`timescale 1ns/1ps
module tb_moxie_wb_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wbi_cyc_i = 0, wbi_stb_i = 0, wbi_we_i = 0;
  logic [AW-1:0] wbi_adr_i = '0;
  logic [DW-1:0] wbi_dat_i = '0;
  logic [SW-1:0] wbi_sel_i = '0;
  logic          wbd_cyc_i = 0, wbd_stb_i = 0, wbd_we_i = 0;
  logic [AW-1:0] wbd_adr_i = '0;
  logic [DW-1:0] wbd_dat_i = '0;
  logic [SW-1:0] wbd_sel_i = '0;
  logic [DW-1:0] wbs_dat_i = '0;
  logic          wbs_ack_i = 0, wbs_err_i = 0;

  logic [DW-1:0] wbi_dat_o, wbd_dat_o, wbs_dat_o;
  logic          wbi_ack_o, wbi_err_o, wbd_ack_o, wbd_err_o;
  logic          wbs_cyc_o, wbs_stb_o, wbs_we_o;
  logic [AW-1:0] wbs_adr_o;
  logic [SW-1:0] wbs_sel_o;
  logic [1:0]    grant_o;

  int nAssert = 0;
  int nFail   = 0;

  // Model: owner 0 = nobody, 1 = I, 2 = D; last 0 = I, 1 = D; cnt = unanswered strobe cycles.
  int mOwner = 0;
  int mLast  = 0;
  int mCnt   = 0;

  always #5 clk = ~clk;

  moxie_wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO), .RESET_LAST(1'b0)) dut (
    .clk_i(clk), .rst_i(rst),
    .wbi_cyc_i(wbi_cyc_i), .wbi_stb_i(wbi_stb_i), .wbi_we_i(wbi_we_i),
    .wbi_adr_i(wbi_adr_i), .wbi_dat_i(wbi_dat_i), .wbi_sel_i(wbi_sel_i),
    .wbi_dat_o(wbi_dat_o), .wbi_ack_o(wbi_ack_o), .wbi_err_o(wbi_err_o),
    .wbd_cyc_i(wbd_cyc_i), .wbd_stb_i(wbd_stb_i), .wbd_we_i(wbd_we_i),
    .wbd_adr_i(wbd_adr_i), .wbd_dat_i(wbd_dat_i), .wbd_sel_i(wbd_sel_i),
    .wbd_dat_o(wbd_dat_o), .wbd_ack_o(wbd_ack_o), .wbd_err_o(wbd_err_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
    .grant_o(grant_o)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nAssert++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  function automatic logic ownCyc(input int o);
    return (o == 1) ? wbi_cyc_i : (o == 2) ? wbd_cyc_i : 1'b0;
  endfunction

  function automatic logic ownStb(input int o);
    return ownCyc(o) && ((o == 1) ? wbi_stb_i : wbd_stb_i);
  endfunction

  function automatic logic ownTimeout(input int o, input int cnt);
    return ownStb(o) && (cnt == TO) && !wbs_ack_i;
  endfunction

  always @(posedge clk or posedge rst) begin
    int nOwner;
    int nLast;
    if (rst) begin
      mOwner <= 0;
      mLast  <= 0;
      mCnt   <= 0;
    end else begin
      nOwner = mOwner;
      nLast  = mLast;
      if (mOwner != 0 && !ownCyc(mOwner)) begin
        nLast  = mOwner - 1;
        nOwner = 0;
      end
      if (nOwner == 0) begin
        if (wbi_cyc_i && wbd_cyc_i) nOwner = (nLast == 0) ? 2 : 1;
        else if (wbi_cyc_i)         nOwner = 1;
        else if (wbd_cyc_i)         nOwner = 2;
      end
      if (nOwner != mOwner || !ownStb(mOwner) || wbs_ack_i || wbs_err_i ||
          ownTimeout(mOwner, mCnt))
        mCnt <= 0;
      else
        mCnt <= mCnt + 1;
      mOwner <= nOwner;
      mLast  <= nLast;
    end
  end

  always @(negedge clk) begin
    logic        stb, ack, err;
    logic [31:0] expAdr, expDat, expSel;
    logic        expWe;
    if (!rst) begin
      stb    = ownStb(mOwner);
      ack    = wbs_ack_i && stb;
      err    = (wbs_err_i && stb) || ownTimeout(mOwner, mCnt);
      expWe  = (mOwner == 1) ? wbi_we_i : (mOwner == 2) ? wbd_we_i : 1'b0;
      expAdr = (mOwner == 1) ? wbi_adr_i : (mOwner == 2) ? wbd_adr_i : '0;
      expDat = (mOwner == 1) ? wbi_dat_i : (mOwner == 2) ? wbd_dat_i : '0;
      expSel = (mOwner == 1) ? 32'(wbi_sel_i) : (mOwner == 2) ? 32'(wbd_sel_i) : '0;
      checkOutput("m_grant", 32'(grant_o),
                  (mOwner == 1) ? 32'd1 : (mOwner == 2) ? 32'd2 : 32'd0);
      checkOutput("m_wbs_cyc", 32'(wbs_cyc_o), 32'(ownCyc(mOwner)));
      checkOutput("m_wbs_stb", 32'(wbs_stb_o), 32'(stb));
      checkOutput("m_wbs_we", 32'(wbs_we_o), 32'(expWe));
      checkOutput("m_wbs_adr", wbs_adr_o, expAdr);
      checkOutput("m_wbs_dat", wbs_dat_o, expDat);
      checkOutput("m_wbs_sel", 32'(wbs_sel_o), expSel);
      checkOutput("m_wbi_ack", 32'(wbi_ack_o), 32'(ack && mOwner == 1));
      checkOutput("m_wbd_ack", 32'(wbd_ack_o), 32'(ack && mOwner == 2));
      checkOutput("m_wbi_err", 32'(wbi_err_o), 32'(err && mOwner == 1));
      checkOutput("m_wbd_err", 32'(wbd_err_o), 32'(err && mOwner == 2));
      if (mOwner == 1) checkOutput("m_wbi_dat", wbi_dat_o, wbs_dat_i);
      if (mOwner == 2) checkOutput("m_wbd_dat", wbd_dat_o, wbs_dat_i);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    {wbi_cyc_i, wbi_stb_i, wbi_we_i, wbd_cyc_i, wbd_stb_i, wbd_we_i} = '0;
    wbi_adr_i = '0; wbi_dat_i = '0; wbi_sel_i = '0;
    wbd_adr_i = '0; wbd_dat_i = '0; wbd_sel_i = '0;
    wbs_ack_i = 0;  wbs_err_i = 0;  wbs_dat_i = '0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    clearInputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic applyStimulus(input bit deaf);
    int dropOdds;
    dropOdds = deaf ? 31 : 7;
    if (wbi_cyc_i) begin
      if ($urandom_range(dropOdds) == 0) wbi_cyc_i = 1'b0;
    end else if ($urandom_range(3) == 0) wbi_cyc_i = 1'b1;
    if (wbd_cyc_i) begin
      if ($urandom_range(dropOdds) == 0) wbd_cyc_i = 1'b0;
    end else if ($urandom_range(3) == 0) wbd_cyc_i = 1'b1;
    wbi_stb_i = wbi_cyc_i && (deaf || $urandom_range(3) != 0);
    wbd_stb_i = wbd_cyc_i && (deaf || $urandom_range(3) != 0);
    wbi_we_i  = ($urandom_range(1) == 1);
    wbd_we_i  = ($urandom_range(1) == 1);
    wbi_adr_i = $urandom;  wbd_adr_i = $urandom;
    wbi_dat_i = $urandom;  wbd_dat_i = $urandom;
    wbi_sel_i = SW'($urandom_range(15));
    wbd_sel_i = SW'($urandom_range(15));
    wbs_ack_i = !deaf && ($urandom_range(2) == 0);
    wbs_err_i = !deaf && ($urandom_range(15) == 0);
    wbs_dat_i = $urandom;
  endtask

  initial begin
    // Reset holds every output low even with both masters and the slave active.
    rst = 1'b1;
    wbi_cyc_i = 1; wbi_stb_i = 1; wbd_cyc_i = 1; wbd_stb_i = 1;
    wbs_ack_i = 1; wbs_err_i = 1; wbs_dat_i = 32'hDEADBEEF;
    step();
    checkOutput("rst_grant", 32'(grant_o), 32'd0);
    checkOutput("rst_wbs_cyc", 32'(wbs_cyc_o), 32'd0);
    checkOutput("rst_wbs_stb", 32'(wbs_stb_o), 32'd0);
    checkOutput("rst_wbi_ack", 32'(wbi_ack_o), 32'd0);
    checkOutput("rst_wbd_err", 32'(wbd_err_o), 32'd0);
    checkOutput("rst_wbi_dat", wbi_dat_o, 32'd0);
    clearInputs();
    @(posedge clk);
    #1 rst = 1'b0;

    // Single I read: one cycle of arbitration latency, ack routed to I only.
    wbi_cyc_i = 1; wbi_stb_i = 1; wbi_adr_i = 32'h0000_1000;
    #3 checkOutput("i_latency_grant", 32'(grant_o), 32'd0);
    step();
    #3 checkOutput("i_grant", 32'(grant_o), 32'd1);
    checkOutput("i_wbs_adr", wbs_adr_o, 32'h0000_1000);
    wbs_ack_i = 1; wbs_dat_i = 32'h1234_5678;
    #1 checkOutput("i_ack", 32'(wbi_ack_o), 32'd1);
    checkOutput("i_d_ack", 32'(wbd_ack_o), 32'd0);
    checkOutput("i_dat", wbi_dat_o, 32'h1234_5678);
    step();
    wbs_ack_i = 0; wbi_cyc_i = 0; wbi_stb_i = 0;
    repeat (2) step();

    // Tie from reset goes to D, then zero-bubble handover to I.
    doReset();
    wbi_cyc_i = 1; wbi_stb_i = 1; wbd_cyc_i = 1; wbd_stb_i = 1;
    step();
    #3 checkOutput("tie_d_first", 32'(grant_o), 32'd2);
    wbd_cyc_i = 0; wbd_stb_i = 0;
    #1 checkOutput("tie_wbs_cyc_follows", 32'(wbs_cyc_o), 32'd0);
    step();
    #3 checkOutput("tie_handover", 32'(grant_o), 32'd1);
    wbi_cyc_i = 0; wbi_stb_i = 0;
    repeat (2) step();

    // D burst of 4 acks is never split by I's request.
    doReset();
    wbd_cyc_i = 1; wbd_stb_i = 1; wbd_we_i = 1; wbd_adr_i = 32'h2000; wbd_dat_i = 32'hCAFE0000;
    step();
    wbi_cyc_i = 1; wbi_stb_i = 1;
    for (int b = 0; b < 4; b++) begin
      wbs_ack_i = 1;
      #3 checkOutput("burst_d_ack", 32'(wbd_ack_o), 32'd1);
      checkOutput("burst_i_ack", 32'(wbi_ack_o), 32'd0);
      checkOutput("burst_grant", 32'(grant_o), 32'd2);
      step();
    end
    wbs_ack_i = 0; wbd_cyc_i = 0; wbd_stb_i = 0;
    #3 checkOutput("burst_hold", 32'(grant_o), 32'd2);
    step();
    #3 checkOutput("burst_handover", 32'(grant_o), 32'd1);
    wbi_cyc_i = 0; wbi_stb_i = 0;
    repeat (2) step();

    // Deaf slave: one error pulse on the 9th strobe cycle, grant kept.
    doReset();
    wbi_cyc_i = 1; wbi_stb_i = 1;
    step();
    for (int k = 1; k <= 9; k++) begin
      #3 checkOutput("wd_err", 32'(wbi_err_o), (k == 9) ? 32'd1 : 32'd0);
      checkOutput("wd_grant", 32'(grant_o), 32'd1);
      step();
    end
    #3 checkOutput("wd_err_after", 32'(wbi_err_o), 32'd0);
    wbi_cyc_i = 0; wbi_stb_i = 0;
    repeat (2) step();

    // Ack in the expiry cycle wins and restarts the count.
    doReset();
    wbd_cyc_i = 1; wbd_stb_i = 1;
    step();
    for (int k = 1; k <= 18; k++) begin
      wbs_ack_i = (k == 9);
      #3;
      if (k == 9) begin
        checkOutput("ackwin_ack", 32'(wbd_ack_o), 32'd1);
        checkOutput("ackwin_err", 32'(wbd_err_o), 32'd0);
      end else begin
        checkOutput("ackwin_restart_err", 32'(wbd_err_o), (k == 18) ? 32'd1 : 32'd0);
      end
      step();
    end
    wbs_ack_i = 0; wbd_cyc_i = 0; wbd_stb_i = 0;
    repeat (2) step();

    // Async reset mid-write drops the bus immediately; I then wins normally.
    doReset();
    wbd_cyc_i = 1; wbd_stb_i = 1; wbd_we_i = 1; wbd_adr_i = 32'h3000; wbd_dat_i = 32'h55AA55AA;
    step();
    #2 checkOutput("midrst_pre_cyc", 32'(wbs_cyc_o), 32'd1);
    checkOutput("midrst_pre_grant", 32'(grant_o), 32'd2);
    #1 rst = 1'b1; wbs_ack_i = 1;
    #1 checkOutput("midrst_cyc", 32'(wbs_cyc_o), 32'd0);
    checkOutput("midrst_stb", 32'(wbs_stb_o), 32'd0);
    checkOutput("midrst_grant", 32'(grant_o), 32'd0);
    checkOutput("midrst_ack", 32'(wbd_ack_o), 32'd0);
    clearInputs();
    @(posedge clk);
    #1 rst = 1'b0;
    wbi_cyc_i = 1; wbi_stb_i = 1;
    #3 checkOutput("postrst_idle", 32'(grant_o), 32'd0);
    step();
    #3 checkOutput("postrst_grant", 32'(grant_o), 32'd1);
    step();

    // Randomized traffic with periodic deaf-slave windows, checked by the model every cycle.
    doReset();
    for (int i = 0; i < 3000; i++) begin
      applyStimulus((i % 150) >= 100);
      step();
    end
    clearInputs();
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
